// File: rtl/exception_sequencer.sv
// exception_sequencer: trap/eret PC-source sequencer with EPC save and vector fetch; define EXC_CAUSE_EN to add the cause output.
module exception_sequencer #(
    parameter int          MEM_LATENCY = 2,
    parameter logic [31:0] VEC_BASE    = 32'd253
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  ctl_pc_source,
    input  logic        ctl_pc_write,
    input  logic        trap_opcode,
    input  logic        trap_overflow,
    input  logic        trap_div0,
    input  logic        eret,
    input  logic [31:0] pc_current,
    input  logic [7:0]  mem_data_in,
    output logic [2:0]  pc_source,
    output logic        pc_write,
    output logic [31:0] epc_output,
    output logic [31:0] exception_address,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        busy
`ifdef EXC_CAUSE_EN
    ,
    output logic [1:0]  cause
`endif
);
    typedef enum logic [2:0] {IDLE, SAVE, WAIT, LOAD, JUMP, RET} state_t;
    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] epc_q, epc_d, exc_q, exc_d, addr_q, addr_d;
    logic        trap;
    logic [1:0]  off;
    assign trap = trap_opcode | trap_overflow | trap_div0;
    assign off  = trap_opcode ? 2'd0 : trap_overflow ? 2'd1 : 2'd2;
    // next-state and output decode; only IDLE passes the main control through
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        epc_d     = epc_q;
        exc_d     = exc_q;
        addr_d    = addr_q;
        pc_source = 3'd0;
        pc_write  = 1'b0;
        mem_read  = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                pc_source = ctl_pc_source;
                pc_write  = ctl_pc_write;
                busy      = 1'b0;
                addr_d    = trap ? VEC_BASE + {30'b0, off} : addr_q;
                state_d   = trap ? SAVE : eret ? RET : IDLE;
            end
            SAVE: begin
                mem_read = 1'b1;
                epc_d    = pc_current - 32'd4;
                cnt_d    = 3'(MEM_LATENCY - 1);
                state_d  = (MEM_LATENCY == 1) ? LOAD : WAIT;
            end
            WAIT: begin
                cnt_d   = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
                state_d = (cnt_q == 3'd0) ? LOAD : WAIT;
            end
            LOAD: begin
                exc_d   = {24'b0, mem_data_in};
                state_d = JUMP;
            end
            JUMP: begin
                pc_source = 3'd4;
                pc_write  = 1'b1;
                state_d   = IDLE;
            end
            RET: begin
                pc_source = 3'd3;
                pc_write  = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // state and datapath registers; reset abandons any in-flight fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            epc_q   <= 32'd0;
            exc_q   <= 32'd0;
            addr_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            epc_q   <= epc_d;
            exc_q   <= exc_d;
            addr_q  <= addr_d;
        end
    end
    assign epc_output        = epc_q;
    assign exception_address = exc_q;
    assign mem_addr          = addr_q;
`ifdef EXC_CAUSE_EN
    logic [1:0] cause_q, cause_d;
    // cause is captured with the winning trap and cleared when a return completes
    always_comb cause_d = (state_q == IDLE && trap) ? off + 2'd1 : (state_q == RET) ? 2'd0 : cause_q;
    // cause register
    always_ff @(posedge clk) begin
        if (reset) cause_q <= 2'd0;
        else cause_q <= cause_d;
    end
    assign cause = cause_q;
`endif
endmodule

// File: tb/tb_exception_sequencer.sv
// tb_exception_sequencer: directed and randomized checks against a cycle-count reference model.
module tb_exception_sequencer;
    localparam int          L  = 2;
    localparam logic [31:0] VB = 32'd253;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  ctl_pc_source;
    logic        ctl_pc_write;
    logic        trap_opcode, trap_overflow, trap_div0, eret;
    logic [31:0] pc_current;
    logic [7:0]  mem_data_in;
    logic [2:0]  pc_source;
    logic        pc_write;
    logic [31:0] epc_output, exception_address, mem_addr;
    logic        mem_read, busy;
`ifdef EXC_CAUSE_EN
    logic [1:0]  cause;
`endif
    logic [7:0]  mem [256];
    int          pend = -1;
    logic [31:0] pend_addr;
    logic [31:0] exp_epc = 0, exp_exc = 0;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    exception_sequencer #(.MEM_LATENCY(L), .VEC_BASE(VB)) dut (
        .clk(clk), .reset(reset),
        .ctl_pc_source(ctl_pc_source), .ctl_pc_write(ctl_pc_write),
        .trap_opcode(trap_opcode), .trap_overflow(trap_overflow), .trap_div0(trap_div0),
        .eret(eret), .pc_current(pc_current), .mem_data_in(mem_data_in),
        .pc_source(pc_source), .pc_write(pc_write), .epc_output(epc_output),
        .exception_address(exception_address), .mem_addr(mem_addr),
        .mem_read(mem_read), .busy(busy)
`ifdef EXC_CAUSE_EN
        , .cause(cause)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // memory: data appears L cycles after a read strobe and stays until the next strobe
    task automatic cyc();
        if (mem_read === 1'b1) begin
            pend_addr   = mem_addr;
            pend        = L;
            mem_data_in = 8'($urandom);
        end
        @(posedge clk);
        #1;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                mem_data_in = mem[pend_addr[7:0]];
                pend = -1;
            end
        end
    endtask

    task automatic rand_ctl();
        ctl_pc_source = 3'($urandom);
        ctl_pc_write  = 1'($urandom);
    endtask

    task automatic idle_chk(input string tag);
        #1;
        chk({tag, ".pc_source"}, 32'(pc_source), 32'(ctl_pc_source));
        chk({tag, ".pc_write"}, 32'(pc_write), 32'(ctl_pc_write));
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".mem_read"}, 32'(mem_read), 32'd0);
    endtask

    task automatic run_trap(input logic [2:0] bits, input logic er, input logic [31:0] pc, input logic disturb);
        logic [1:0]  off;
        logic [31:0] vaddr;
        off   = bits[0] ? 2'd0 : bits[1] ? 2'd1 : 2'd2;
        vaddr = VB + 32'(off);
        trap_opcode = bits[0]; trap_overflow = bits[1]; trap_div0 = bits[2];
        eret = er; pc_current = pc;
        rand_ctl();
        idle_chk("trap_entry");
        cyc();
        trap_opcode = 0; trap_overflow = 0; trap_div0 = 0; eret = 0;
        for (int k = 0; k <= L + 2; k++) begin
            if (k > 0) pc_current = $urandom;
            if (disturb && k > 0) begin
                trap_opcode = 1'($urandom); trap_overflow = 1'($urandom);
                trap_div0 = 1'($urandom); eret = 1'($urandom);
                rand_ctl();
            end
            #1;
            chk("seq.busy", 32'(busy), 32'd1);
            chk("seq.pc_write", 32'(pc_write), 32'(k == L + 2));
            chk("seq.mem_read", 32'(mem_read), 32'(k == 0));
            chk("seq.mem_addr", mem_addr, vaddr);
            if (k == L + 2) begin
                chk("jump.pc_source", 32'(pc_source), 32'd4);
                chk("jump.exc_addr", exception_address, {24'b0, mem[vaddr[7:0]]});
                chk("jump.epc", epc_output, pc - 32'd4);
            end
            cyc();
        end
        trap_opcode = 0; trap_overflow = 0; trap_div0 = 0; eret = 0;
        exp_epc = pc - 32'd4;
        exp_exc = {24'b0, mem[vaddr[7:0]]};
        rand_ctl();
        idle_chk("trap_exit");
        chk("hold.epc", epc_output, exp_epc);
        chk("hold.exc", exception_address, exp_exc);
`ifdef EXC_CAUSE_EN
        chk("cause", 32'(cause), 32'(off) + 32'd1);
`endif
        cyc();
    endtask

    task automatic run_eret();
        eret = 1;
        rand_ctl();
        idle_chk("eret_entry");
        cyc();
        eret = 0;
        rand_ctl();
        #1;
        chk("ret.pc_source", 32'(pc_source), 32'd3);
        chk("ret.pc_write", 32'(pc_write), 32'd1);
        chk("ret.busy", 32'(busy), 32'd1);
        chk("ret.epc", epc_output, exp_epc);
        cyc();
        rand_ctl();
        idle_chk("ret_exit");
`ifdef EXC_CAUSE_EN
        chk("ret.cause", 32'(cause), 32'd0);
`endif
        cyc();
    endtask

    task automatic run_idle();
        rand_ctl();
        idle_chk("idle");
        chk("idle.epc", epc_output, exp_epc);
        chk("idle.exc", exception_address, exp_exc);
        cyc();
    endtask

    task automatic run_reset_in_wait();
        trap_overflow = 1; pc_current = $urandom;
        cyc();
        trap_overflow = 0;
        cyc();
        reset = 1;
        ctl_pc_write = 0;
        cyc();
        reset = 0;
        ctl_pc_source = 3'($urandom);
        ctl_pc_write = 0;
        idle_chk("rst_wait");
        chk("rst_wait.exc", exception_address, 32'd0);
        chk("rst_wait.epc", epc_output, 32'd0);
        chk("rst_wait.mem_addr", mem_addr, 32'd0);
`ifdef EXC_CAUSE_EN
        chk("rst_wait.cause", 32'(cause), 32'd0);
`endif
        exp_epc = 0; exp_exc = 0;
        for (int i = 0; i < L + 3; i++) begin
            cyc();
            #1;
            chk("rst_wait.no_jump", 32'(pc_write), 32'd0);
            chk("rst_wait.idle_busy", 32'(busy), 32'd0);
        end
        cyc();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        reset = 1; ctl_pc_source = 0; ctl_pc_write = 0;
        trap_opcode = 0; trap_overflow = 0; trap_div0 = 0; eret = 0;
        pc_current = 0; mem_data_in = 0;
        cyc(); cyc();
        ctl_pc_source = 3'd2; ctl_pc_write = 1;
        #1;
        chk("reset.pc_source", 32'(pc_source), 32'd2);
        chk("reset.pc_write", 32'(pc_write), 32'd1);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.epc", epc_output, 32'd0);
        chk("reset.exc", exception_address, 32'd0);
        chk("reset.mem_addr", mem_addr, 32'd0);
        chk("reset.mem_read", 32'(mem_read), 32'd0);
        reset = 0;
        cyc();
        mem[254] = 8'h80;
        run_trap(3'b010, 1'b0, 32'h0000_0104, 1'b0);
        run_trap(3'b101, 1'b0, 32'h0000_2000, 1'b1);
        run_eret();
        run_trap(3'b100, 1'b1, 32'h0000_0002, 1'b1);
        run_idle();
        run_reset_in_wait();
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: run_trap(3'($urandom_range(1, 7)), 1'($urandom), $urandom, 1'($urandom));
                1: run_eret();
                2: run_idle();
                default: run_reset_in_wait();
            endcase
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
